adc_stream_packer: RTL and testbench
====================================

Name: adc_stream_packer

Overview:
- Parametrised successor to the single-pair ADC data path.
- Accepts N demuxed ADC channels per sample set in the system clock domain, then applies:
  - optional decimation;
  - offset-binary to two's-complement conversion;
  - packing into 32-bit words, two 16-bit samples per word.
- Buffers packed words in a first-word-fall-through FIFO read by the bus-side logic.
- Sits between the DCO-domain capture/CDC stage and the register/DMA interface.

Parameters:
AdcRes, 14, ADC sample width in bits; legal range 8..16.
NumCh, 2, channels per sample set; legal values 1, 2, 4.
FifoDepth, 512, FIFO depth in 32-bit words; must be a power of two, minimum 4.
DecimW, 8, width of the decimation-ratio input.

Ports:
clk_sys_i  in  1  system clock; all logic is in this domain.
rst_sys_clk_ni  in  1  asynchronous active-low reset.
enable_i  in  1  stream enable; when low the packer is idle and decimation is cleared.
decim_i  in  DecimW  keep 1 of every (decim_i+1) sample sets.
twos_comp_i  in  1  1 = invert the MSB (offset binary to two's complement), then sign-extend; 0 = zero-extend.
sample_valid_i  in  1  samples_i holds a new set this cycle.
samples_i  in  NumCh*AdcRes  channel k occupies bits [k*AdcRes +: AdcRes].
rd_en_i  in  1  pop the FIFO head.
data_o  out  32  FIFO head; valid while empty_o=0.
empty_o  out  1  FIFO empty.
full_o  out  1  FIFO full.
overflow_o  out  1  sticky loss flag.
clr_overflow_i  in  1  clears overflow_o.
level_o  out  $clog2(FifoDepth)+1  FIFO occupancy.

Behaviour:
- Reset values: data_o=0, empty_o=1, full_o=0, overflow_o=0, level_o=0. FIFO pointers, decimation counter, pack state and half-word register are all cleared.
- Extension:
  - each sample s becomes a 16-bit value e;
  - twos_comp_i=1: e = sign-extend({~s[MSB], s[MSB-1:0]});
  - twos_comp_i=0: e = zero-extend(s).
- Decimation:
  - the counter runs 0..decim_i and advances on each sample_valid_i while enable_i=1;
  - a set is accepted only when the counter = 0;
  - decim_i=0 accepts every set;
  - a new decim_i value takes effect at the next wrap to 0.
- Packing, by NumCh:
  - NumCh=2: accepted set writes one word {e1,e0}.
  - NumCh=1: the first accepted sample is held in the half-word register; the second writes {e_new,e_held}.
  - NumCh=4: uses a two-state FSM.
    - S_IDLE: an accepted set writes {e1,e0} and latches {e3,e2}, then moves to S_HI.
    - S_HI: writes {e3,e2}, then returns to S_IDLE.
    - An accepted set arriving while in S_HI is dropped and sets overflow_o.
- Latency: a word is written one cycle after acceptance (registered pack stage). It is visible on data_o with empty_o=0 two cycles after sample_valid_i.
- FIFO behaviour:
  - First-word-fall-through.
  - rd_en_i while empty is ignored.
  - A write while full with rd_en_i=0 drops the word and sets overflow_o.
  - A write while full with rd_en_i=1 is accepted; level is unchanged.
  - Simultaneous read and write at other levels leaves level_o unchanged.
  - Pointers wrap modulo FifoDepth; full is detected with an extra MSB pointer bit.
- enable_i falling:
  - clears the decimation counter and discards any held half-word or pending high word;
  - leaves FIFO contents readable.
- clr_overflow_i in the same cycle as a new overflow event: set wins.
- An asynchronous reset mid-stream empties the FIFO immediately.

Optional Feature:
- Macro: ADC_TEST_PATTERN_EN.
- Defined:
  - adds input test_pattern_i (1 bit);
  - when it is high, channel k's sample is replaced by an AdcRes-bit ramp counter plus k;
  - the ramp increments per accepted set, wraps modulo 2^AdcRes, and is reset to 0 by enable_i low;
  - extension and packing are unchanged.
- Undefined: the port and ramp logic are absent; samples_i is always used.

Decimation:
- Not applicable. The decimation behaviour is specified under Behaviour.

Decomposition:
- Package adc_stream_pkg holds:
  - localparams for the 16-bit lane width and 32-bit word width;
  - the FSM state enum (S_IDLE, S_HI);
  - the function for the extension rule.
- One sub-module, sync_fwft_fifo (parameters Width and Depth), holds the FIFO with level, full, empty and overflow-on-drop outputs.

Test Plan:
- NumCh=2, AdcRes=14, twos_comp_i=0, samples 0x1234/0x0ABC, decim_i=0 -> data_o=0x12340ABC two cycles later, level_o=1.
- twos_comp_i=1, sample 0x0000 -> lane 0xE000; sample 0x3FFF -> lane 0x1FFF.
- decim_i=3, 16 consecutive valid sets -> exactly 4 words, from sets 0, 4, 8 and 12.
- NumCh=4, a set every other cycle -> words {e1,e0} then {e3,e2}; back-to-back sets -> second set dropped and overflow_o=1.
- Fill to FifoDepth -> full_o=1; one further write -> dropped, overflow_o=1. Write plus rd_en_i at full -> accepted, level_o=FifoDepth.
- ADC_TEST_PATTERN_EN, NumCh=1, test_pattern_i=1 -> words 0x00010000, 0x00030002, and so on. Reset asserted mid-stream -> empty_o=1 immediately.

Source files
------------

// File: rtl/adc_stream_pkg.sv
// Shared types and helpers for the ADC stream packer.
// Provides the lane/word widths, the 4-channel pack FSM states, and the
// sample extension rule (offset-binary to two's complement or zero-extend).
package adc_stream_pkg;

  localparam int LaneW = 16;
  localparam int WordW = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HI   = 1'b1
  } pack_state_e;

  // raw holds an res-bit sample right-aligned. With twos=1 the MSB is
  // inverted and that inverted bit is replicated upward (sign extension).
  function automatic logic [LaneW-1:0] extend_sample(input logic [LaneW-1:0] raw,
                                                     input int               res,
                                                     input logic             twos);
    logic [LaneW-1:0] e;
    logic             msb_n;
    msb_n = ~raw[4'(res-1)];
    e     = '0;
    for (int i = 0; i < LaneW; i++) begin
      if (i < res - 1)    e[i] = raw[i];
      else if (twos)      e[i] = msb_n;
      else if (i == res - 1) e[i] = raw[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy and drop report.
// Latency: a write is visible on rd_data_o the cycle after it is clocked in.
// Backpressure: none upstream; a write while full without a read is dropped
// and flagged on drop_o. Ports: clk_i/rst_ni, wr_en_i/wr_data_i, rd_en_i,
// rd_data_o (0 when empty), empty_o, full_o, drop_o, level_o.
module sync_fwft_fifo #(
  parameter int Width = 32,
  parameter int Depth = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [Width-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     drop_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en_i && !empty_o;
  // At full, a simultaneous pop frees the slot being written.
  assign do_wr   = wr_en_i && (!full_o || do_rd);
  assign drop_o  = wr_en_i && full_o && !do_rd;
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/adc_stream_packer.sv
// Decimates, extends and packs N ADC channels into 32-bit words in a FWFT FIFO.
// Latency: word written one cycle after acceptance, on data_o two cycles after sample_valid_i.
// Backpressure: none; words lost at a full FIFO or a busy 4-channel packer set overflow_o.
// Ports: clk_sys_i/rst_sys_clk_ni, enable_i, decim_i, twos_comp_i, sample_valid_i,
// samples_i, rd_en_i, data_o, empty_o, full_o, overflow_o, clr_overflow_i, level_o.
// Optional macro ADC_TEST_PATTERN_EN adds test_pattern_i and a per-set ramp source.
module adc_stream_packer
  import adc_stream_pkg::*;
#(
  parameter int AdcRes    = 14,
  parameter int NumCh     = 2,
  parameter int FifoDepth = 512,
  parameter int DecimW    = 8
) (
  input  logic                        clk_sys_i,
  input  logic                        rst_sys_clk_ni,
  input  logic                        enable_i,
  input  logic [DecimW-1:0]           decim_i,
  input  logic                        twos_comp_i,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                        test_pattern_i,
`endif
  input  logic                        sample_valid_i,
  input  logic [NumCh*AdcRes-1:0]     samples_i,
  input  logic                        rd_en_i,
  output logic [WordW-1:0]            data_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic                        overflow_o,
  input  logic                        clr_overflow_i,
  output logic [$clog2(FifoDepth):0]  level_o
);

  logic [DecimW-1:0] dec_cnt_q, dec_cnt_d;
  logic [DecimW-1:0] ratio_q, ratio_d, ratio_eff;
  logic              accept;
  logic [LaneW-1:0]  lane [4];

  pack_state_e       state_q;
  logic              wr_vld_q;
  logic [WordW-1:0]  wr_dat_q;
  logic [WordW-1:0]  hi_q;
  logic [LaneW-1:0]  half_q;
  logic              half_vld_q;
  logic              fsm_drop, fifo_drop;
  logic              overflow_q, overflow_d;

`ifdef ADC_TEST_PATTERN_EN
  logic [AdcRes-1:0] ramp_q;

  always_ff @(posedge clk_sys_i or negedge rst_sys_clk_ni) begin
    if (!rst_sys_clk_ni)  ramp_q <= '0;
    else if (!enable_i)   ramp_q <= '0;
    else if (accept)      ramp_q <= ramp_q + AdcRes'(1);
  end
`endif

  for (genvar k = 0; k < 4; k++) begin : g_lane
    if (k < NumCh) begin : g_act
      logic [AdcRes-1:0] raw;
`ifdef ADC_TEST_PATTERN_EN
      assign raw = test_pattern_i ? ramp_q + AdcRes'(k) : samples_i[k*AdcRes +: AdcRes];
`else
      assign raw = samples_i[k*AdcRes +: AdcRes];
`endif
      assign lane[k] = extend_sample(LaneW'(raw), AdcRes, twos_comp_i);
    end else begin : g_unused
      assign lane[k] = '0;
    end
  end

  // A ratio change is picked up only when the counter sits at 0, so a
  // decimation period in progress always completes with its old ratio.
  assign ratio_eff = (dec_cnt_q == '0) ? decim_i : ratio_q;
  assign accept    = enable_i && sample_valid_i && (dec_cnt_q == '0);

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    ratio_d   = ratio_q;
    if (!enable_i) begin
      dec_cnt_d = '0;
      ratio_d   = decim_i;
    end else if (sample_valid_i) begin
      if (dec_cnt_q == '0) ratio_d = decim_i;
      dec_cnt_d = (dec_cnt_q >= ratio_eff) ? '0 : dec_cnt_q + DecimW'(1);
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_clk_ni) begin
    if (!rst_sys_clk_ni) begin
      dec_cnt_q <= '0;
      ratio_q   <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      ratio_q   <= ratio_d;
    end
  end

  // Pack stage: single registered block covering all channel counts; the
  // NumCh == 4 branch is the S_IDLE/S_HI FSM.
  always_ff @(posedge clk_sys_i or negedge rst_sys_clk_ni) begin
    if (!rst_sys_clk_ni) begin
      state_q    <= S_IDLE;
      wr_vld_q   <= 1'b0;
      wr_dat_q   <= '0;
      hi_q       <= '0;
      half_q     <= '0;
      half_vld_q <= 1'b0;
    end else begin
      wr_vld_q <= 1'b0;
      if (!enable_i) begin
        state_q    <= S_IDLE;
        half_vld_q <= 1'b0;
      end else if (NumCh == 1) begin
        if (accept) begin
          if (half_vld_q) begin
            wr_vld_q   <= 1'b1;
            wr_dat_q   <= {lane[0], half_q};
            half_vld_q <= 1'b0;
          end else begin
            half_q     <= lane[0];
            half_vld_q <= 1'b1;
          end
        end
      end else if (NumCh == 2) begin
        if (accept) begin
          wr_vld_q <= 1'b1;
          wr_dat_q <= {lane[1], lane[0]};
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              wr_vld_q <= 1'b1;
              wr_dat_q <= {lane[1], lane[0]};
              hi_q     <= {lane[3], lane[2]};
              state_q  <= S_HI;
            end
          end
          S_HI: begin
            wr_vld_q <= 1'b1;
            wr_dat_q <= hi_q;
            state_q  <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // The packer can only emit one word per cycle, so a set accepted while
  // the high word is still pending has nowhere to go.
  assign fsm_drop = (NumCh == 4) && accept && (state_q == S_HI);

  sync_fwft_fifo #(
    .Width (WordW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i     (clk_sys_i),
    .rst_ni    (rst_sys_clk_ni),
    .wr_en_i   (wr_vld_q),
    .wr_data_i (wr_dat_q),
    .rd_en_i   (rd_en_i),
    .rd_data_o (data_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .drop_o    (fifo_drop),
    .level_o   (level_o)
  );

  // Set has priority over clear so a loss coincident with a clear is kept.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_overflow_i)          overflow_d = 1'b0;
    if (fifo_drop || fsm_drop)   overflow_d = 1'b1;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_clk_ni) begin
    if (!rst_sys_clk_ni) overflow_q <= 1'b0;
    else                 overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_adc_stream_packer.sv
// Bench for adc_stream_packer: three instances (2, 4 and 1 channels, 8-deep FIFOs).
// Stimulus pushes expected words into per-instance queues; a monitor pops and
// compares whenever an instance presents a word and its pop budget allows it.
module tb_adc_stream_packer;

  logic clk;
  logic rst_n;
  logic [7:0] decim;
  logic twos;
  logic clr;
`ifdef ADC_TEST_PATTERN_EN
  logic tp;
`endif

  logic en2, valid2, rd2, empty2, full2, ov2;
  logic [27:0] smp2;
  logic [31:0] data2;
  logic [3:0]  level2;

  logic en4, valid4, rd4, empty4, full4, ov4;
  logic [55:0] smp4;
  logic [31:0] data4;
  logic [3:0]  level4;

  logic en1, valid1, rd1, empty1, full1, ov1;
  logic [13:0] smp1;
  logic [31:0] data1;
  logic [3:0]  level1;

  int tests = 0;
  int fails = 0;
  int budget [3];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adc_stream_packer #(.AdcRes(14), .NumCh(2), .FifoDepth(8), .DecimW(8)) u2 (
    .clk_sys_i(clk), .rst_sys_clk_ni(rst_n), .enable_i(en2), .decim_i(decim),
    .twos_comp_i(twos),
`ifdef ADC_TEST_PATTERN_EN
    .test_pattern_i(tp),
`endif
    .sample_valid_i(valid2), .samples_i(smp2), .rd_en_i(rd2), .data_o(data2),
    .empty_o(empty2), .full_o(full2), .overflow_o(ov2), .clr_overflow_i(clr),
    .level_o(level2));

  adc_stream_packer #(.AdcRes(14), .NumCh(4), .FifoDepth(8), .DecimW(8)) u4 (
    .clk_sys_i(clk), .rst_sys_clk_ni(rst_n), .enable_i(en4), .decim_i(decim),
    .twos_comp_i(twos),
`ifdef ADC_TEST_PATTERN_EN
    .test_pattern_i(tp),
`endif
    .sample_valid_i(valid4), .samples_i(smp4), .rd_en_i(rd4), .data_o(data4),
    .empty_o(empty4), .full_o(full4), .overflow_o(ov4), .clr_overflow_i(clr),
    .level_o(level4));

  adc_stream_packer #(.AdcRes(14), .NumCh(1), .FifoDepth(8), .DecimW(8)) u1 (
    .clk_sys_i(clk), .rst_sys_clk_ni(rst_n), .enable_i(en1), .decim_i(decim),
    .twos_comp_i(twos),
`ifdef ADC_TEST_PATTERN_EN
    .test_pattern_i(tp),
`endif
    .sample_valid_i(valid1), .samples_i(smp1), .rd_en_i(rd1), .data_o(data1),
    .empty_o(empty1), .full_o(full1), .overflow_o(ov1), .clr_overflow_i(clr),
    .level_o(level1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decide a pop for one instance: compare the head with the scoreboard and
  // assert rd so the head is consumed at the next rising edge.
  task automatic pop_cmp(input int id, input logic [31:0] d, input logic emp, output logic rd);
    logic [31:0] exp;
    int sz;
    rd = 1'b0;
    if (!emp && budget[id] > 0) begin
      budget[id]--;
      rd = 1'b1;
      case (id)
        0: sz = q0.size();
        1: sz = q1.size();
        default: sz = q2.size();
      endcase
      if (sz == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word dut%0d: got 0x%0h, expected no word", id, d);
      end else begin
        case (id)
          0: exp = q0.pop_front();
          1: exp = q1.pop_front();
          default: exp = q2.pop_front();
        endcase
        check($sformatf("word_dut%0d", id), d, exp);
      end
    end
  endtask

  initial begin
    rd2 = 1'b0; rd4 = 1'b0; rd1 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      pop_cmp(0, data2, empty2, rd2);
      pop_cmp(1, data4, empty4, rd4);
      pop_cmp(2, data1, empty1, rd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "timeout");
  end

  task automatic send2(input logic [27:0] s);
    @(negedge clk); valid2 = 1'b1; smp2 = s;
    @(negedge clk); valid2 = 1'b0;
  endtask

  task automatic send4(input logic [55:0] s);
    @(negedge clk); valid4 = 1'b1; smp4 = s;
    @(negedge clk); valid4 = 1'b0;
  endtask

  task automatic send1(input logic [13:0] s);
    @(negedge clk); valid1 = 1'b1; smp1 = s;
    @(negedge clk); valid1 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && empty2 && empty4 && empty1) break;
    end
    check("drain_pending", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  initial begin
    logic [13:0] a, b;
    rst_n = 1'b0; decim = '0; twos = 1'b0; clr = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
    tp = 1'b0;
`endif
    en2 = 1'b0; valid2 = 1'b0; smp2 = '0;
    en4 = 1'b0; valid4 = 1'b0; smp4 = '0;
    en1 = 1'b0; valid1 = 1'b0; smp1 = '0;
    budget[0] = 0; budget[1] = 1000; budget[2] = 1000;

    #12;
    check("rst_data", data2, 32'h0);
    check("rst_empty", 32'(empty2), 32'd1);
    check("rst_full", 32'(full2), 32'd0);
    check("rst_overflow", 32'(ov2), 32'd0);
    check("rst_level", 32'(level2), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); en2 = 1'b1; en4 = 1'b1; en1 = 1'b1;

    // First word and its two-cycle latency.
    @(negedge clk); valid2 = 1'b1; smp2 = {14'h1234, 14'h0ABC};
    q0.push_back(32'h12340ABC);
    @(posedge clk); #3;
    check("lat1_empty", 32'(empty2), 32'd1);
    @(negedge clk); valid2 = 1'b0;
    @(posedge clk); #3;
    check("lat2_empty", 32'(empty2), 32'd0);
    check("lat2_data", data2, 32'h12340ABC);
    check("lat2_level", 32'(level2), 32'd1);
    budget[0] = 1000;

    // Extension rules.
    twos = 1'b1;
    send2({14'h3FFF, 14'h0000}); q0.push_back(32'h1FFFE000);
    send2({14'h2000, 14'h1FFF}); q0.push_back(32'h0000FFFF);
    twos = 1'b0;
    send2({14'h3FFF, 14'h2000}); q0.push_back(32'h3FFF2000);
    wait_drain();

    // Decimation by 4 over 16 back-to-back sets.
    decim = 8'd3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a = 14'(256 + i); b = 14'(i);
      valid2 = 1'b1; smp2 = {a, b};
      if (i % 4 == 0) q0.push_back({16'(256 + i), 16'(i)});
    end
    @(negedge clk); valid2 = 1'b0; decim = '0;
    wait_drain();

    // Fill, drop at full, clear, then write plus read at full.
    budget[0] = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = 14'(512 + i); b = 14'(768 + i);
      valid2 = 1'b1; smp2 = {a, b};
      q0.push_back({16'(512 + i), 16'(768 + i)});
    end
    @(negedge clk); valid2 = 1'b0;
    repeat (3) @(negedge clk);
    check("fill_full", 32'(full2), 32'd1);
    check("fill_level", 32'(level2), 32'd8);
    check("fill_no_overflow", 32'(ov2), 32'd0);
    send2({14'h3AAA, 14'h1555});
    repeat (3) @(negedge clk);
    check("drop_overflow", 32'(ov2), 32'd1);
    check("drop_level", 32'(level2), 32'd8);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr_overflow", 32'(ov2), 32'd0);
    @(negedge clk); valid2 = 1'b1; smp2 = {14'h0111, 14'h0222};
    q0.push_back(32'h01110222);
    budget[0] = 1;
    @(negedge clk); valid2 = 1'b0;
    @(negedge clk);
    check("wr_rd_full_level", 32'(level2), 32'd8);
    check("wr_rd_full_full", 32'(full2), 32'd1);
    check("wr_rd_full_no_ovf", 32'(ov2), 32'd0);
    budget[0] = 1000;
    wait_drain();

    // Four channels: spaced sets, then a back-to-back pair.
    send4({14'h4, 14'h3, 14'h2, 14'h1});
    q1.push_back(32'h00020001); q1.push_back(32'h00040003);
    @(negedge clk);
    check("ch4_spaced_no_ovf", 32'(ov4), 32'd0);
    @(negedge clk); valid4 = 1'b1; smp4 = {14'h14, 14'h13, 14'h12, 14'h11};
    q1.push_back(32'h00120011); q1.push_back(32'h00140013);
    @(negedge clk); smp4 = {14'h24, 14'h23, 14'h22, 14'h21};
    @(negedge clk); valid4 = 1'b0;
    repeat (2) @(negedge clk);
    check("ch4_b2b_overflow", 32'(ov4), 32'd1);
    wait_drain();

    // One channel: pairing, and a held half discarded by enable low.
    send1(14'h5); send1(14'h6); q2.push_back(32'h00060005);
    send1(14'h7);
    @(negedge clk); en1 = 1'b0;
    @(negedge clk); en1 = 1'b1;
    send1(14'h8); send1(14'h9); q2.push_back(32'h00090008);
`ifdef ADC_TEST_PATTERN_EN
    @(negedge clk); en1 = 1'b0;
    @(negedge clk); en1 = 1'b1; tp = 1'b1;
    for (int i = 0; i < 4; i++) send1(14'h3333);
    q2.push_back(32'h00010000); q2.push_back(32'h00030002);
    tp = 1'b0;
`endif
    wait_drain();

    // Asynchronous reset with a word sitting in the FIFO.
    budget[2] = 0;
    send1(14'hA); send1(14'hB);
    repeat (2) @(negedge clk);
    check("pre_reset_empty", 32'(empty1), 32'd0);
    check("pre_reset_data", data1, 32'h000B000A);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_empty", 32'(empty1), 32'd1);
    check("async_reset_level", 32'(level1), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    check("final_q_size", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
